// File: rtl/conc_pkg.sv
// Shared constants for the response-capture trace buffer: default sizes and
// the layout of a stored record {obs, chg, data}.
package conc_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int DW_DEF    = 6;

    function automatic int rec_w(input int dw);
        return dw + 2;
    endfunction

    function automatic int obs_bit(input int dw);
        return dw + 1;
    endfunction

    function automatic int chg_bit(input int dw);
        return dw;
    endfunction

endpackage

// File: rtl/conc_sync_fifo.sv
// Single-clock FIFO holding capture records. A write into a full FIFO is
// accepted only when a read is accepted on the same edge.
module conc_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_wr_en,
    input  logic [W-1:0]               i_wr_data,
    input  logic                       i_rd_en,
    output logic [W-1:0]               o_head,
    output logic                       o_rd_acc,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_empty;
    logic          w_wr_acc;

    assign w_empty  = (r_count == '0);
    assign o_full   = (r_count == CW'(DEPTH));
    assign o_rd_acc = i_rd_en && !w_empty;
    assign w_wr_acc = i_wr_en && (!o_full || o_rd_acc);
    assign o_head   = r_mem[r_rd_ptr];
    assign o_count  = r_count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (o_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr_acc, o_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (reset && w_wr_acc) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/conc_resp_capture.sv
// Captures DUT response words on change, on observation strobes, or on the
// first enabled cycle, into a trace FIFO drained through a 1-cycle read port.
module conc_resp_capture
    import conc_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DW-1:0]            x_out_i,
    input  logic                     obs_i,
    input  logic                     en,
    input  logic                     rd_en,
    output logic [rec_w(DW)-1:0]     rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [31:0]              cyc_cnt
);

    localparam int RW    = rec_w(DW);
    localparam int OBS_B = obs_bit(DW);
    localparam int CHG_B = chg_bit(DW);

    logic [DW-1:0] r_last;
    logic          r_first;
    logic [RW-1:0] r_rd_data;
    logic          r_rd_valid;
    logic          r_overflow;
    logic [31:0]   r_cyc_cnt;

    logic          w_chg;
    logic          w_cap;
    logic [RW-1:0] w_rec;
    logic [RW-1:0] w_head;
    logic          w_rd_acc;
    logic          w_full;

    assign w_chg = r_first || (x_out_i != r_last);
    assign w_cap = en && (obs_i || w_chg);

    always_comb begin
        w_rec          = '0;
        w_rec[DW-1:0]  = x_out_i;
        w_rec[CHG_B]   = w_chg;
        w_rec[OBS_B]   = obs_i;
    end

    conc_sync_fifo #(.DEPTH(DEPTH), .W(RW)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .i_wr_en   (w_cap),
        .i_wr_data (w_rec),
        .i_rd_en   (rd_en),
        .o_head    (w_head),
        .o_rd_acc  (w_rd_acc),
        .o_full    (w_full),
        .o_count   (count)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_last     <= '0;
            r_first    <= 1'b1;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_overflow <= 1'b0;
            r_cyc_cnt  <= '0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) r_rd_data <= w_head;
            // A same-edge read frees the slot, so only an unmatched capture is lost.
            if (w_cap && w_full && !w_rd_acc) r_overflow <= 1'b1;
            if (en) begin
                r_last    <= x_out_i;
                r_first   <= 1'b0;
                r_cyc_cnt <= r_cyc_cnt + 32'd1;
            end else begin
                r_first   <= 1'b1;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign overflow = r_overflow;
    assign cyc_cnt  = r_cyc_cnt;

endmodule

// File: tb/tb_conc_resp_capture.sv
// Bench for conc_resp_capture: directed vector table, corner sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_conc_resp_capture;

    localparam int DEPTH = 16;
    localparam int DW    = 6;
    localparam int RW    = DW + 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] x_out_i = '0;
    logic          obs_i = 1'b0;
    logic          en = 1'b0;
    logic          rd_en = 1'b0;
    logic [RW-1:0] rd_data;
    logic          rd_valid;
    logic [CW-1:0] count;
    logic          overflow;
    logic [31:0]   cyc_cnt;

    always #5 clock = ~clock;

    conc_resp_capture #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clock    (clock),
        .reset    (reset),
        .x_out_i  (x_out_i),
        .obs_i    (obs_i),
        .en       (en),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count),
        .overflow (overflow),
        .cyc_cnt  (cyc_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: the buffer is just a queue of records.
    logic [RW-1:0] m_q[$];
    logic [DW-1:0] m_last  = '0;
    bit            m_first = 1'b1;
    int unsigned   m_cyc   = 0;
    bit            m_ovf   = 1'b0;
    bit            m_v     = 1'b0;
    logic [RW-1:0] m_d     = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic e, input logic [DW-1:0] x,
                              input logic o, input logic rd);
        bit            acc, chg, cap;
        logic [RW-1:0] rec;
        if (!r) begin
            m_q.delete();
            m_last = '0; m_first = 1'b1; m_cyc = 0; m_ovf = 1'b0;
            m_v = 1'b0; m_d = '0;
        end else begin
            acc = rd && (m_q.size() > 0);
            chg = m_first || (x != m_last);
            cap = e && (o || chg);
            rec = {o, chg, x};
            m_v = acc;
            if (acc) m_d = m_q.pop_front();
            if (cap) begin
                if (m_q.size() < DEPTH) m_q.push_back(rec);
                else m_ovf = 1'b1;
            end
            if (e) begin
                m_last = x; m_first = 1'b0; m_cyc++;
            end else begin
                m_first = 1'b1;
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [DW-1:0] x,
                        input logic o, input logic rd);
        @(negedge clock);
        reset = r; en = e; x_out_i = x; obs_i = o; rd_en = rd;
        @(posedge clock);
        model_edge(r, e, x, o, rd);
        #1;
        chk("model count",    32'(count),    32'(m_q.size()));
        chk("model rd_valid", 32'(rd_valid), 32'(m_v));
        chk("model rd_data",  32'(rd_data),  32'(m_d));
        chk("model overflow", 32'(overflow), 32'(m_ovf));
        chk("model cyc_cnt",  cyc_cnt,       m_cyc);
    endtask

    typedef struct {
        logic          r;
        logic          e;
        logic [DW-1:0] x;
        logic          o;
        logic          rd;
        int            cnt;
        logic          v;
        logic [RW-1:0] d;
        int            cyc;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // Hand-derived vectors: 0x05 held, 01/01(obs)/02, read on empty + first capture
        tbl[0]  = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 0};
        tbl[1]  = '{1'b1, 1'b1, 6'h05, 1'b0, 1'b0, 1, 1'b0, 8'h00, 1};
        tbl[2]  = '{1'b1, 1'b1, 6'h05, 1'b0, 1'b0, 1, 1'b0, 8'h00, 2};
        tbl[3]  = '{1'b1, 1'b1, 6'h05, 1'b0, 1'b0, 1, 1'b0, 8'h00, 3};
        tbl[4]  = '{1'b1, 1'b0, 6'h05, 1'b0, 1'b1, 0, 1'b1, 8'h45, 3};
        tbl[5]  = '{1'b1, 1'b1, 6'h01, 1'b0, 1'b0, 1, 1'b0, 8'h45, 4};
        tbl[6]  = '{1'b1, 1'b1, 6'h01, 1'b1, 1'b0, 2, 1'b0, 8'h45, 5};
        tbl[7]  = '{1'b1, 1'b1, 6'h02, 1'b0, 1'b0, 3, 1'b0, 8'h45, 6};
        tbl[8]  = '{1'b1, 1'b0, 6'h02, 1'b0, 1'b1, 2, 1'b1, 8'h41, 6};
        tbl[9]  = '{1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 1, 1'b1, 8'h81, 6};
        tbl[10] = '{1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 0, 1'b1, 8'h42, 6};
        tbl[11] = '{1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 0, 1'b0, 8'h42, 6};
        tbl[12] = '{1'b1, 1'b1, 6'h0A, 1'b0, 1'b1, 1, 1'b0, 8'h42, 7};
        tbl[13] = '{1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 0, 1'b1, 8'h4A, 7};

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].x, tbl[i].o, tbl[i].rd);
            chk($sformatf("vec%0d count", i),    32'(count),    32'(tbl[i].cnt));
            chk($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(tbl[i].v));
            chk($sformatf("vec%0d rd_data", i),  32'(rd_data),  32'(tbl[i].d));
            chk($sformatf("vec%0d cyc_cnt", i),  cyc_cnt,       32'(tbl[i].cyc));
            chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'd0);
        end

        // Overfill with DEPTH+2 distinct words, then drain in order
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 1'b1, DW'(i + 1), 1'b0, 1'b0);
        chk("ovf count", 32'(count), 32'(DEPTH));
        chk("ovf flag", 32'(overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, '0, 1'b0, 1'b1);
            chk("ovf drain valid", 32'(rd_valid), 32'd1);
            chk("ovf drain data", 32'(rd_data), 32'({2'b01, DW'(i + 1)}));
        end
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("ovf idle valid", 32'(rd_valid), 32'd0);
        chk("ovf sticky", 32'(overflow), 32'd1);

        // Full buffer: read and capture on the same edge
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, DW'(i + 1), 1'b0, 1'b0);
        step(1'b1, 1'b1, 6'h3F, 1'b0, 1'b1);
        chk("full rw count", 32'(count), 32'(DEPTH));
        chk("full rw overflow", 32'(overflow), 32'd0);
        chk("full rw data", 32'(rd_data), 32'h41);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("full rw last rec", 32'(rd_data), 32'h7F);
        chk("full rw empty", 32'(count), 32'd0);

        // Reset in the middle of a drain
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 1'b1, DW'(i + 1), 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("mid count before", 32'(count), 32'd5);
        step(1'b0, 1'b1, 6'h11, 1'b1, 1'b1);
        chk("mid rst count", 32'(count), 32'd0);
        chk("mid rst valid", 32'(rd_valid), 32'd0);
        chk("mid rst cyc", cyc_cnt, 32'd0);
        chk("mid rst ovf", 32'(overflow), 32'd0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("mid rst stale read", 32'(rd_valid), 32'd0);

        // Randomized traffic against the model
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 3) != 0),
                 DW'($urandom_range(0, 3)),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 9) < 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conc_resp_capture.md
CONC_RESP_CAPTURE -- requirements
Module: conc_resp_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 16, buffer entries (power of two, 4..64).
REQ-002 SHALL have parameter DW, default 6, DUT response data width.
REQ-003 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port x_out_i  input  DW  DUT response word, sampled every clock.
REQ-006 SHALL have port obs_i  input  1  observation strobe from the stimulus side.
REQ-007 SHALL have port en  input  1  capture enable.
REQ-008 SHALL have port rd_en  input  1  read request from the trace drain.
REQ-009 SHALL have port rd_data  output  DW+2  record {obs, chg, data}, bit DW+1 = obs.
REQ-010 SHALL have port rd_valid  output  1  rd_data valid, one-cycle pulse.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  current buffer occupancy.
REQ-012 SHALL have port overflow  output  1  sticky: a capture was dropped.
REQ-013 SHALL have port cyc_cnt  output  32  count of enabled sample cycles.

Function
REQ-014 SHALL sample x_out_i and obs_i on every rising edge where en=1.
REQ-015 SHALL raise a capture event when en=1 and any of these holds: obs_i=1; x_out_i differs from the last sampled word; the cycle is the first en=1 cycle after reset or after en=0.
REQ-016 SHALL form the record as {obs_i, chg, x_out_i}, with chg=1 when x_out_i differs from the last word or the cycle is a first cycle, else chg=0.
REQ-017 SHALL update the last-word register on every en=1 cycle, whether or not the capture is stored.
REQ-018 SHALL write the record to the buffer tail in the same cycle when the buffer is not full.
REQ-019 SHALL drop a capture event when the buffer is full and no read is accepted in the same cycle, and SHALL set overflow to 1.
REQ-020 SHALL accept both operations when rd_en=1 and a capture occur together on a full buffer; count stays at DEPTH and overflow is unchanged.
REQ-021 SHALL accept rd_en=1 only when count>0; rd_data SHALL be driven from the head entry and rd_valid=1 on the following cycle (latency 1).
REQ-022 SHALL ignore rd_en=1 on an empty buffer (rd_valid=0 next cycle), even if a capture is written in the same cycle.
REQ-023 SHALL hold rd_data at its last value when rd_valid=0.
REQ-024 SHALL increment cyc_cnt by 1 on each en=1 cycle and wrap from 0xFFFFFFFF to 0.
REQ-025 SHALL wrap the head and tail pointers modulo DEPTH; count SHALL equal writes minus reads, in the range 0..DEPTH.
REQ-026 SHALL keep overflow at 1 until reset.
REQ-027 SHALL perform no capture, and leave cyc_cnt unchanged, while en=0; reads SHALL continue to operate.

Reset
REQ-028 SHALL, when reset=0 at a rising edge, clear count, the pointers, overflow, cyc_cnt, rd_data, rd_valid and the last-word register to 0, and re-arm the first-cycle flag.
REQ-029 SHALL discard buffer contents and any in-flight read when reset is asserted mid-operation; rd_valid SHALL be 0 in the cycle after reset.
REQ-030 SHALL ignore all inputs during any cycle in which reset=0.

Structure
REQ-031 SHALL take DEPTH/DW defaults, the record width (DW+2) and the record bit positions from shared package conc_pkg.
REQ-032 SHALL implement the buffer as sub-module conc_sync_fifo (write, read, full, empty, count); capture logic and counters live in the top module.

Verification
REQ-033 Scenario: reset, en=1, x_out_i=0x05 held for 3 cycles with obs_i=0 -> exactly 1 record 0x45 (chg=1), count=1, cyc_cnt=3.
REQ-034 Scenario: x_out_i sequence 0x01,0x01,0x02 with obs_i=1 on cycle 2 -> records 0x41, 0x81, 0x42.
REQ-035 Scenario: DEPTH+2 distinct words with no reads -> count=16, overflow=1, the first 16 words read back in order with rd_valid one cycle after each rd_en.
REQ-036 Scenario: full buffer, rd_en=1 together with a new capture 0x3F -> count stays 16, overflow stays 0, and 0x7F is the last record drained.
REQ-037 Scenario: rd_en=1 on an empty buffer, same cycle as the first capture -> rd_valid=0, count=1.
REQ-038 Scenario: reset=0 mid-drain with count=5 -> next cycle count=0, rd_valid=0, cyc_cnt=0, overflow=0.
